// File: rtl/analyzer_capture_ctrl_pkg.sv
// Shared definitions for the logic-analyzer capture path: FSM state encoding
// and the capture status bit layout seen by register-file readback.
package analyzer_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_FILL  = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_e;

    localparam int STAT_BUSY_BIT      = 0;
    localparam int STAT_TRIGGERED_BIT = 1;
    localparam int STAT_DONE_BIT      = 2;
    localparam int STAT_WIDTH         = 3;

    function automatic logic [STAT_WIDTH-1:0] pack_status(
        input logic busy,
        input logic triggered,
        input logic done
    );
        logic [STAT_WIDTH-1:0] stat_s;
        stat_s                     = '0;
        stat_s[STAT_BUSY_BIT]      = busy;
        stat_s[STAT_TRIGGERED_BIT] = triggered;
        stat_s[STAT_DONE_BIT]      = done;
        return stat_s;
    endfunction

endpackage

// File: rtl/analyzer_capture_ctrl.sv
// Capture controller: pre/post-trigger windowing into a circular sample buffer,
// publishing the trigger address and the oldest valid sample address.
module analyzer_capture_ctrl
    import analyzer_capture_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  trig_in,
    input  logic [ADDR_WIDTH-1:0] pre_depth,
    output logic                  buf_we,
    output logic [ADDR_WIDTH-1:0] buf_waddr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    cap_state_e            state_r;
    logic [ADDR_WIDTH-1:0] wptr_r;
    logic [ADDR_WIDTH-1:0] pre_lat_r;
    logic [ADDR_WIDTH-1:0] pre_cnt_r;
    logic [ADDR_WIDTH-1:0] post_cnt_r;
    logic                  buf_we_r;
    logic [ADDR_WIDTH-1:0] buf_waddr_r;
    logic [DATA_WIDTH-1:0] buf_wdata_r;
    logic                  busy_r;
    logic                  triggered_r;
    logic                  done_r;
    logic [ADDR_WIDTH-1:0] trig_addr_r;
    logic [ADDR_WIDTH-1:0] start_addr_r;

    // Capture FSM, write path and window counters, all registered together.
    // pre_depth is ADDR_WIDTH bits wide, so it can never exceed DEPTH-1 and
    // the pre-trigger clamp reduces to taking pre_depth as-is.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            wptr_r       <= '0;
            pre_lat_r    <= '0;
            pre_cnt_r    <= '0;
            post_cnt_r   <= '0;
            buf_we_r     <= 1'b0;
            buf_waddr_r  <= '0;
            buf_wdata_r  <= '0;
            busy_r       <= 1'b0;
            triggered_r  <= 1'b0;
            done_r       <= 1'b0;
            trig_addr_r  <= '0;
            start_addr_r <= '0;
        end else begin
            buf_we_r <= 1'b0;
            if (abort) begin
                state_r     <= ST_IDLE;
                busy_r      <= 1'b0;
                triggered_r <= 1'b0;
                done_r      <= 1'b0;
            end else begin
                if (busy_r && sample_en) begin
                    buf_we_r    <= 1'b1;
                    buf_waddr_r <= wptr_r;
                    buf_wdata_r <= din;
                    wptr_r      <= wptr_r + ADDR_ONE;
                end
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            pre_lat_r    <= pre_depth;
                            post_cnt_r   <= ADDR_MAX - pre_depth;
                            pre_cnt_r    <= '0;
                            wptr_r       <= '0;
                            triggered_r  <= 1'b0;
                            done_r       <= 1'b0;
                            trig_addr_r  <= '0;
                            start_addr_r <= '0;
                            busy_r       <= 1'b1;
                            state_r      <= (pre_depth != '0) ? ST_PRE_FILL : ST_WAIT_TRIG;
                        end
                    end
                    ST_PRE_FILL: begin
                        if (sample_en) begin
                            pre_cnt_r <= pre_cnt_r + ADDR_ONE;
                            if ((pre_cnt_r + ADDR_ONE) == pre_lat_r) begin
                                state_r <= ST_WAIT_TRIG;
                            end
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (sample_en && trig_in) begin
                            trig_addr_r  <= wptr_r;
                            start_addr_r <= wptr_r - pre_lat_r;
                            triggered_r  <= 1'b1;
                            if (post_cnt_r != '0) begin
                                state_r <= ST_POST;
                            end else begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end
                    end
                    ST_POST: begin
                        if (sample_en) begin
                            post_cnt_r <= post_cnt_r - ADDR_ONE;
                            if (post_cnt_r == ADDR_ONE) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign buf_we     = buf_we_r;
    assign buf_waddr  = buf_waddr_r;
    assign buf_wdata  = buf_wdata_r;
    assign busy       = busy_r;
    assign triggered  = triggered_r;
    assign done       = done_r;
    assign trig_addr  = trig_addr_r;
    assign start_addr = start_addr_r;

endmodule

// File: tb/tb_analyzer_capture_ctrl.sv
// Bench for analyzer_capture_ctrl: table of capture scenarios plus random
// captures, checked against a sample-list window model, and hand sequences.
module tb_analyzer_capture_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          sample_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          trig_in = 1'b0;
    logic [AW-1:0] pre_depth = '0;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [DW-1:0] buf_wdata;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;

    always #5 clk = ~clk;

    analyzer_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .sample_en(sample_en), .din(din), .trig_in(trig_in), .pre_depth(pre_depth),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .busy(busy), .triggered(triggered), .done(done),
        .trig_addr(trig_addr), .start_addr(start_addr)
    );

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] mem [DEPTH];

    // en_mode: 0 always, 1 alternate, 2 random. trig_kind: 0 only at sample
    // trig_at, 1 from sample trig_at onward, 2 random. exp_* < 0: model only.
    typedef struct {
        int pre;
        int en_mode;
        int trig_kind;
        int trig_at;
        int inj_start;
        int exp_trig;
        int exp_start;
        int exp_writes;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic se, input logic tr, input logic [DW-1:0] d,
                        input logic st, input logic ab);
        sample_en = se;
        trig_in   = tr;
        din       = d;
        start     = st;
        abort     = ab;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_capture(input string tag, input vec_t v);
        logic [DW-1:0] smp_din[$];
        bit            smp_trig[$];
        logic [AW-1:0] wa[$];
        logic [DW-1:0] wd[$];
        logic          se, tr, st;
        logic [DW-1:0] d;
        int k = 0, cyc = 0, we_err = 0, busy_err = 0, mism = 0, win_err = 0;
        int pl, t, exp_n;
        bit fin = 1'b0;
        pre_depth = v.pre[AW-1:0];
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_trig_clear_at_start"}, {triggered, done}, 0);
        pre_depth = AW'($urandom);
        while (!fin && cyc < 400) begin
            case (v.en_mode)
                0:       se = 1'b1;
                1:       se = (cyc % 2 == 1);
                default: se = 1'($urandom_range(0, 1));
            endcase
            if (se) begin
                d = (v.trig_kind == 2) ? $urandom : DW'(k);
                case (v.trig_kind)
                    0:       tr = (k == v.trig_at);
                    1:       tr = (k >= v.trig_at);
                    default: tr = ($urandom_range(0, 7) == 0);
                endcase
                smp_din.push_back(d);
                smp_trig.push_back(tr);
            end else begin
                d  = 32'hDEAD_0000 + DW'(cyc);
                tr = 1'b1;
            end
            st = se && (k == v.inj_start);
            step(se, tr, d, st, 1'b0);
            if (se) k++;
            if (buf_we !== se) we_err++;
            if (buf_we === 1'b1) begin
                wa.push_back(buf_waddr);
                wd.push_back(buf_wdata);
                mem[buf_waddr] = buf_wdata;
            end
            if (done === 1'b1) begin
                fin = 1'b1;
                check({tag, "_done_with_final_we"}, buf_we, 1);
            end else if (busy !== 1'b1) begin
                busy_err++;
            end
            cyc++;
        end
        check({tag, "_done_reached"}, fin, 1);
        check({tag, "_we_follows_sample_en"}, we_err, 0);
        check({tag, "_busy_while_capturing"}, busy_err, 0);
        // Reference: trigger is the first trig sample at index >= pre_lat;
        // every sample from index 0 through trigger + post count is written.
        pl = (v.pre > DEPTH - 1) ? DEPTH - 1 : v.pre;
        t  = -1;
        for (int i = pl; i < smp_trig.size(); i++) begin
            if (smp_trig[i]) begin
                t = i;
                break;
            end
        end
        check({tag, "_trigger_sample_seen"}, (t >= 0), 1);
        if (t < 0) return;
        exp_n = t + DEPTH - pl;
        check({tag, "_write_count"}, wa.size(), exp_n);
        for (int i = 0; i < wa.size() && i < exp_n; i++) begin
            if (wa[i] !== AW'(i % DEPTH) || wd[i] !== smp_din[i]) mism++;
        end
        check({tag, "_write_stream_errors"}, mism, 0);
        check({tag, "_trig_addr"}, trig_addr, t % DEPTH);
        check({tag, "_start_addr"}, start_addr, (t - pl) % DEPTH);
        check({tag, "_flags_after_done"}, {busy, triggered, done}, 3'b011);
        for (int i = 0; i < DEPTH; i++) begin
            if (i + t - pl < smp_din.size()) begin
                if (mem[(t - pl + i) % DEPTH] !== smp_din[t - pl + i]) win_err++;
            end else begin
                win_err++;
            end
        end
        check({tag, "_window_errors"}, win_err, 0);
        if (v.exp_trig >= 0) begin
            check({tag, "_tbl_trig_addr"}, trig_addr, v.exp_trig);
            check({tag, "_tbl_start_addr"}, start_addr, v.exp_start);
            check({tag, "_tbl_write_count"}, wa.size(), v.exp_writes);
        end
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check({tag, "_no_write_in_done"}, buf_we, 0);
        check({tag, "_done_sticky"}, {done, triggered, trig_addr}, {1'b1, 1'b1, AW'(t % DEPTH)});
    endtask

    initial begin
        vec_t rv;
        tbl[0] = '{4,  0, 0, 10, -1, 10, 6, 22};
        tbl[1] = '{4,  0, 1, 2,  -1, 4,  0, 16};
        tbl[2] = '{0,  0, 0, 0,  -1, 0,  0, 16};
        tbl[3] = '{15, 0, 1, 0,  -1, 15, 0, 16};
        tbl[4] = '{3,  1, 0, 7,  -1, 7,  4, 20};
        tbl[5] = '{2,  1, 1, 5,  -1, 5,  3, 19};
        tbl[6] = '{2,  0, 0, 8,  5,  8,  6, 22};

        #12;
        check("reset_outputs", {buf_we, buf_waddr, buf_wdata, busy, triggered, done, trig_addr, start_addr}, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", {busy, done, buf_we}, 0);

        for (int r = 0; r < 7; r++) begin
            run_capture($sformatf("tbl%0d", r), tbl[r]);
        end
        for (int r = 0; r < 6; r++) begin
            rv = '{int'($urandom_range(0, 15)), 2, 2, 0, -1, -1, -1, -1};
            run_capture($sformatf("rnd%0d", r), rv);
        end

        // Abort in POST with a sample in flight.
        pre_depth = 4'd4;
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 14; k++) step(1'b1, (k == 10), DW'(k), 1'b0, 1'b0);
        check("post_before_abort", {busy, triggered, done}, 3'b110);
        step(1'b1, 1'b0, 32'd14, 1'b0, 1'b1);
        check("abort_outputs", {buf_we, busy, done, triggered}, 0);
        step(1'b1, 1'b1, 32'd15, 1'b0, 1'b0);
        check("abort_stays_idle", {buf_we, busy}, 0);

        // start together with abort in IDLE must not arm.
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("start_abort_idle_busy", busy, 0);
        step(1'b1, 1'b1, 32'd1, 1'b0, 1'b0);
        check("start_abort_idle_no_write", {buf_we, triggered}, 0);

        // Asynchronous reset in the middle of POST, off the clock edge.
        pre_depth = 4'd4;
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 14; k++) step(1'b1, (k == 10), DW'(k), 1'b0, 1'b0);
        check("pre_reset_writing", {buf_we, triggered}, 2'b11);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_ctrl", {buf_we, busy, triggered, done}, 0);
        check("async_reset_addr", {buf_waddr, trig_addr, start_addr}, 0);
        check("async_reset_data", buf_wdata, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run_capture("after_reset", tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
